// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle controller and the IR/ALU datapath, memory and I/O ports.
// Handshakes: FETCH/LWRD/SWWR complete in the cycle MemReady=1, IN in the cycle InValid=1, OUT in the cycle OutReady=1.
interface mc_control_fsm_if #(
   parameter int OPW   = 4,
   parameter int FUNKW = 3
);
   logic [OPW-1:0]   Opcode;
   logic [FUNKW-1:0] funk;
   logic             Zero;
   logic             MemReady;
   logic             InValid;
   logic             OutReady;
   logic [2:0]       ALUOp;
   logic             SrcA;
   logic [1:0]       SrcB;
   logic [1:0]       MemtoReg;
   logic [1:0]       RegDest;
   logic             RegWrite;
   logic             MemRead;
   logic             MemWrite;
   logic             MemSrc;
   logic             IRWrite;
   logic             OutputWrite;
   logic             InAck;
   logic             PCWrite;
   logic [1:0]       PCSrc;
   logic             Trap;
   logic [1:0]       TrapCause;
   logic [4:0]       current_state;

   modport master (
      input  Opcode, funk, Zero, MemReady, InValid, OutReady,
      output ALUOp, SrcA, SrcB, MemtoReg, RegDest, RegWrite, MemRead, MemWrite, MemSrc,
             IRWrite, OutputWrite, InAck, PCWrite, PCSrc, Trap, TrapCause, current_state
   );

   modport slave (
      output Opcode, funk, Zero, MemReady, InValid, OutReady,
      input  ALUOp, SrcA, SrcB, MemtoReg, RegDest, RegWrite, MemRead, MemWrite, MemSrc,
             IRWrite, OutputWrite, InAck, PCWrite, PCSrc, Trap, TrapCause, current_state
   );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM: decodes Opcode/funk into datapath selects and enables, with memory
// wait-states plus timeout, in/out handshakes, zero-qualified branches and a trap state.
module mc_control_fsm #(
   parameter int OPW         = 4,
   parameter int FUNKW       = 3,
   parameter int MEM_TIMEOUT = 15
) (
   input logic               CLK,
   input logic               Reset,
   mc_control_fsm_if.master  bus
);
   localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [4:0] {
      S_FETCH = 5'd0, S_DECODE = 5'd1, S_RTYPE = 5'd2, S_RWB = 5'd3, S_MEMADDR = 5'd4,
      S_SWWR = 5'd5, S_LWRD = 5'd6, S_LWWB = 5'd7, S_IMM = 5'd8, S_IMMWB = 5'd9,
      S_JAL1 = 5'd10, S_JAL2 = 5'd11, S_JR = 5'd12, S_JUMP = 5'd13, S_BEQ = 5'd14,
      S_BNE = 5'd15, S_IN = 5'd16, S_OUT = 5'd17, S_TRAP = 5'd18
   } state_t;

   state_t         r_state;
   logic [1:0]     r_cause;
   logic [TW-1:0]  r_tmo;

   logic [3:0]     w_op;
   logic           w_op_hi;
   logic           w_tmo_hit;
   logic [2:0]     w_aluop;
   logic           w_srca, w_memsrc;
   logic [1:0]     w_srcb, w_memtoreg, w_regdest, w_pcsrc;
   logic           w_regwrite, w_memread, w_memwrite, w_irwrite;
   logic           w_outwrite, w_inack, w_pcwrite, w_trap;

   // Any opcode bit above [3] makes the instruction illegal.
   always_comb begin
      w_op_hi = 1'b0;
      for (int i = 4; i < OPW; i++) w_op_hi |= bus.Opcode[i];
   end

   assign w_op      = bus.Opcode[3:0];
   assign w_tmo_hit = (MEM_TIMEOUT != 0) && (r_tmo == TW'(MEM_TIMEOUT - 1));

   // The wait counter idles at zero outside memory states, so every entry starts from zero.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state <= S_FETCH;
         r_cause <= 2'b00;
         r_tmo   <= '0;
      end else begin
         r_tmo <= '0;
         case (r_state)
            S_FETCH, S_LWRD, S_SWWR: begin
               if (bus.MemReady) begin
                  r_state <= (r_state == S_FETCH) ? S_DECODE :
                             (r_state == S_LWRD)  ? S_LWWB : S_FETCH;
               end else if (w_tmo_hit) begin
                  r_state <= S_TRAP;
                  r_cause <= 2'b10;
               end else begin
                  r_tmo <= r_tmo + TW'(1);
               end
            end
            S_DECODE: begin
               if (w_op_hi) begin
                  r_state <= S_TRAP;
                  r_cause <= 2'b01;
               end else begin
                  case (w_op)
                     4'd0:             r_state <= S_RTYPE;
                     4'd1, 4'd4, 4'd5: r_state <= S_IMM;
                     4'd2, 4'd3:       r_state <= S_MEMADDR;
                     4'd7:             r_state <= S_BEQ;
                     4'd8:             r_state <= S_BNE;
                     4'd9:             r_state <= S_JUMP;
                     4'd10:            r_state <= S_JAL1;
                     4'd11:            r_state <= S_JR;
                     4'd12: begin
                        if (bus.funk == FUNKW'(1))      r_state <= S_IN;
                        else if (bus.funk == FUNKW'(0)) r_state <= S_OUT;
                        else begin
                           r_state <= S_TRAP;
                           r_cause <= 2'b11;
                        end
                     end
                     default: begin
                        r_state <= S_TRAP;
                        r_cause <= 2'b01;
                     end
                  endcase
               end
            end
            S_RTYPE:   r_state <= S_RWB;
            S_IMM:     r_state <= S_IMMWB;
            S_MEMADDR: r_state <= (w_op == 4'd2) ? S_LWRD : S_SWWR;
            S_JAL1:    r_state <= S_JAL2;
            S_IN:      if (bus.InValid)  r_state <= S_FETCH;
            S_OUT:     if (bus.OutReady) r_state <= S_FETCH;
            default:   r_state <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      w_aluop    = 3'b000;
      w_srca     = 1'b0;
      w_srcb     = 2'b00;
      w_memtoreg = 2'b00;
      w_regdest  = 2'b00;
      w_pcsrc    = 2'b00;
      w_memsrc   = 1'b0;
      w_regwrite = 1'b0;
      w_memread  = 1'b0;
      w_memwrite = 1'b0;
      w_irwrite  = 1'b0;
      w_outwrite = 1'b0;
      w_inack    = 1'b0;
      w_pcwrite  = 1'b0;
      w_trap     = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_memread = 1'b1;
            w_srcb    = 2'b01;
            w_aluop   = 3'b010;
            w_irwrite = bus.MemReady;
            w_pcwrite = bus.MemReady;
         end
         S_DECODE: begin
            w_srcb  = 2'b11;
            w_aluop = 3'b010;
         end
         S_RTYPE: begin
            w_srca  = 1'b1;
            w_aluop = bus.funk[2:0];
         end
         S_RWB: begin
            w_regwrite = 1'b1;
            w_memtoreg = 2'b01;
            w_regdest  = 2'b01;
         end
         S_IMM: begin
            w_srca  = 1'b1;
            w_srcb  = 2'b10;
            w_aluop = (w_op == 4'd1) ? 3'b010 : (w_op == 4'd4) ? 3'b001 : 3'b000;
         end
         S_IMMWB: begin
            w_regwrite = 1'b1;
            w_memtoreg = 2'b01;
         end
         S_MEMADDR: begin
            w_srca  = 1'b1;
            w_srcb  = 2'b10;
            w_aluop = 3'b010;
         end
         S_LWRD: begin
            w_memread = 1'b1;
            w_memsrc  = 1'b1;
         end
         S_LWWB: w_regwrite = 1'b1;
         S_SWWR: begin
            w_memwrite = 1'b1;
            w_memsrc   = 1'b1;
         end
         S_JAL1: begin
            w_srcb  = 2'b01;
            w_aluop = 3'b010;
         end
         S_JAL2: begin
            w_regwrite = 1'b1;
            w_memtoreg = 2'b01;
            w_regdest  = 2'b11;
            w_pcwrite  = 1'b1;
            w_pcsrc    = 2'b10;
         end
         S_JR: begin
            w_srca    = 1'b1;
            w_aluop   = 3'b100;
            w_pcwrite = 1'b1;
         end
         S_JUMP: begin
            w_pcwrite = 1'b1;
            w_pcsrc   = 2'b10;
         end
         S_BEQ, S_BNE: begin
            w_srca    = 1'b1;
            w_aluop   = 3'b011;
            w_pcsrc   = 2'b01;
            w_pcwrite = (r_state == S_BEQ) ? bus.Zero : ~bus.Zero;
         end
         S_IN: begin
            w_memtoreg = 2'b10;
            w_regdest  = 2'b01;
            w_regwrite = bus.InValid;
            w_inack    = bus.InValid;
         end
         S_OUT: w_outwrite = 1'b1;
         S_TRAP: begin
            w_trap    = 1'b1;
            w_pcwrite = 1'b1;
            w_pcsrc   = 2'b11;
         end
         default: ;
      endcase
   end

   // Enables are masked by Reset combinationally so an in-flight access is killed immediately.
   assign bus.RegWrite      = w_regwrite & ~Reset;
   assign bus.MemRead       = w_memread  & ~Reset;
   assign bus.MemWrite      = w_memwrite & ~Reset;
   assign bus.IRWrite       = w_irwrite  & ~Reset;
   assign bus.PCWrite       = w_pcwrite  & ~Reset;
   assign bus.OutputWrite   = w_outwrite & ~Reset;
   assign bus.InAck         = w_inack    & ~Reset;
   assign bus.Trap          = w_trap     & ~Reset;
   assign bus.ALUOp         = w_aluop;
   assign bus.SrcA          = w_srca;
   assign bus.SrcB          = w_srcb;
   assign bus.MemtoReg      = w_memtoreg;
   assign bus.RegDest       = w_regdest;
   assign bus.MemSrc        = w_memsrc;
   assign bus.PCSrc         = w_pcsrc;
   assign bus.TrapCause     = r_cause;
   assign bus.current_state = r_state;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: one OPW=4/MEM_TIMEOUT=4 instance driven step by step,
// and an OPW=5 instance that sees only opcode 16.
module tb_mc_control_fsm;
   logic CLK = 1'b0;
   logic Reset;
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 CLK = ~CLK;

   mc_control_fsm_if #(.OPW(4), .FUNKW(3)) ifm ();
   mc_control_fsm_if #(.OPW(5), .FUNKW(3)) if5 ();

   mc_control_fsm #(.OPW(4), .FUNKW(3), .MEM_TIMEOUT(4)) dut (
      .CLK(CLK), .Reset(Reset), .bus(ifm.master)
   );
   mc_control_fsm #(.OPW(5), .FUNKW(3), .MEM_TIMEOUT(15)) dut5 (
      .CLK(CLK), .Reset(Reset), .bus(if5.master)
   );

   assign if5.Opcode   = 5'd16;
   assign if5.funk     = 3'd0;
   assign if5.Zero     = 1'b0;
   assign if5.MemReady = 1'b1;
   assign if5.InValid  = 1'b0;
   assign if5.OutReady = 1'b0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic nxt();
      @(posedge CLK);
      #1;
   endtask

   task automatic fetch_decode(input logic [3:0] op, input logic [2:0] fk);
      ifm.Opcode   = op;
      ifm.funk     = fk;
      ifm.MemReady = 1'b1;
      #1;
      chk("fetch_state", ifm.current_state, 8'd0);
      chk("fetch_irwrite", ifm.IRWrite, 8'd1);
      nxt();
      ifm.MemReady = 1'b0;
      #1;
      chk("decode_state", ifm.current_state, 8'd1);
      chk("decode_srcb", ifm.SrcB, 8'd3);
      nxt();
   endtask

   logic [4:0] exp5 [3]    = '{5'd0, 5'd1, 5'd18};
   logic [3:0] br_op [4]   = '{4'd7, 4'd7, 4'd8, 4'd8};
   logic       br_zero [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   logic       br_pcw [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};

   initial begin
      Reset        = 1'b1;
      ifm.Opcode   = 4'd2;
      ifm.funk     = 3'd0;
      ifm.Zero     = 1'b0;
      ifm.MemReady = 1'b0;
      ifm.InValid  = 1'b0;
      ifm.OutReady = 1'b0;
      nxt();
      chk("reset_state", ifm.current_state, 8'd0);
      chk("reset_memread_masked", ifm.MemRead, 8'd0);
      chk("reset_cause", ifm.TrapCause, 8'd0);
      Reset = 1'b0;
      #1;
      chk("fetch_memread", ifm.MemRead, 8'd1);

      // lw with three FETCH and two LWRD wait cycles; OPW=5 instance traps on opcode 16
      for (int i = 0; i < 3; i++) begin
         chk("lw_fetch_wait_state", ifm.current_state, 8'd0);
         chk("lw_fetch_wait_irwrite", ifm.IRWrite, 8'd0);
         chk("lw_fetch_wait_pcwrite", ifm.PCWrite, 8'd0);
         chk("opw5_state", if5.current_state, exp5[i]);
         nxt();
      end
      chk("opw5_cause", if5.TrapCause, 8'd1);
      ifm.MemReady = 1'b1;
      #1;
      chk("lw_fetch_irwrite", ifm.IRWrite, 8'd1);
      chk("lw_fetch_pcwrite", ifm.PCWrite, 8'd1);
      nxt();
      ifm.MemReady = 1'b0;
      #1;
      chk("lw_decode", ifm.current_state, 8'd1);
      chk("lw_decode_irwrite", ifm.IRWrite, 8'd0);
      nxt();
      chk("lw_memaddr", ifm.current_state, 8'd4);
      chk("lw_memaddr_srcb", ifm.SrcB, 8'd2);
      nxt();
      for (int i = 0; i < 2; i++) begin
         chk("lw_lwrd_wait", ifm.current_state, 8'd6);
         chk("lw_lwrd_memsrc", ifm.MemSrc, 8'd1);
         nxt();
      end
      ifm.MemReady = 1'b1;
      #1;
      chk("lw_lwrd_ready", ifm.current_state, 8'd6);
      nxt();
      ifm.MemReady = 1'b0;
      #1;
      chk("lw_lwwb", ifm.current_state, 8'd7);
      chk("lw_lwwb_regwrite", ifm.RegWrite, 8'd1);
      nxt();
      chk("lw_done", ifm.current_state, 8'd0);

      // beq/bne taken and not taken
      for (int i = 0; i < 4; i++) begin
         fetch_decode(br_op[i], 3'd0);
         ifm.Zero = br_zero[i];
         #1;
         chk("br_pcwrite", ifm.PCWrite, {7'd0, br_pcw[i]});
         chk("br_pcsrc", ifm.PCSrc, 8'd1);
         chk("br_aluop", ifm.ALUOp, 8'd3);
         nxt();
         ifm.Zero = 1'b0;
      end

      fetch_decode(4'd0, 3'd3);
      chk("rtype_aluop", ifm.ALUOp, 8'd3);
      nxt();
      chk("rwb_regdest", ifm.RegDest, 8'd1);
      chk("rwb_regwrite", ifm.RegWrite, 8'd1);
      nxt();

      fetch_decode(4'd4, 3'd0);
      chk("ori_state", ifm.current_state, 8'd8);
      chk("ori_aluop", ifm.ALUOp, 8'd1);
      nxt();
      chk("immwb_state", ifm.current_state, 8'd9);
      nxt();

      fetch_decode(4'd10, 3'd0);
      chk("jal1_state", ifm.current_state, 8'd10);
      nxt();
      chk("jal2_pcsrc", ifm.PCSrc, 8'd2);
      chk("jal2_regdest", ifm.RegDest, 8'd3);
      chk("jal2_pcwrite", ifm.PCWrite, 8'd1);
      nxt();

      // sw with memory never ready: trap after four wait cycles
      fetch_decode(4'd3, 3'd0);
      chk("sw_memaddr", ifm.current_state, 8'd4);
      nxt();
      for (int i = 0; i < 4; i++) begin
         chk("sw_wait_state", ifm.current_state, 8'd5);
         chk("sw_wait_memwrite", ifm.MemWrite, 8'd1);
         nxt();
      end
      chk("tmo_trap_state", ifm.current_state, 8'd18);
      chk("tmo_trap_pulse", ifm.Trap, 8'd1);
      chk("tmo_trap_pcsrc", ifm.PCSrc, 8'd3);
      chk("tmo_trap_cause", ifm.TrapCause, 8'd2);
      nxt();
      chk("tmo_after_trap", ifm.Trap, 8'd0);
      chk("tmo_cause_held", ifm.TrapCause, 8'd2);

      fetch_decode(4'd14, 3'd0);
      chk("illegal_state", ifm.current_state, 8'd18);
      chk("illegal_cause", ifm.TrapCause, 8'd1);
      nxt();
      fetch_decode(4'd12, 3'd3);
      chk("badio_cause", ifm.TrapCause, 8'd3);
      nxt();

      fetch_decode(4'd12, 3'd1);
      for (int i = 0; i < 2; i++) begin
         chk("in_wait_state", ifm.current_state, 8'd16);
         chk("in_wait_inack", ifm.InAck, 8'd0);
         chk("in_wait_regwrite", ifm.RegWrite, 8'd0);
         nxt();
      end
      ifm.InValid = 1'b1;
      #1;
      chk("in_inack", ifm.InAck, 8'd1);
      chk("in_regwrite", ifm.RegWrite, 8'd1);
      chk("in_memtoreg", ifm.MemtoReg, 8'd2);
      nxt();
      ifm.InValid = 1'b0;
      #1;
      chk("in_done", ifm.current_state, 8'd0);

      fetch_decode(4'd12, 3'd0);
      for (int i = 0; i < 3; i++) begin
         chk("out_wait_state", ifm.current_state, 8'd17);
         chk("out_wait_write", ifm.OutputWrite, 8'd1);
         nxt();
      end
      ifm.OutReady = 1'b1;
      #1;
      chk("out_xfer_write", ifm.OutputWrite, 8'd1);
      nxt();
      ifm.OutReady = 1'b0;
      #1;
      chk("out_done_state", ifm.current_state, 8'd0);
      chk("out_done_write", ifm.OutputWrite, 8'd0);

      // reset in the middle of a load
      fetch_decode(4'd2, 3'd0);
      nxt();
      chk("rst_lwrd_state", ifm.current_state, 8'd6);
      chk("rst_lwrd_memread", ifm.MemRead, 8'd1);
      Reset = 1'b1;
      #1;
      chk("rst_memread_killed", ifm.MemRead, 8'd0);
      nxt();
      Reset = 1'b0;
      #1;
      chk("rst_state", ifm.current_state, 8'd0);
      chk("rst_cause", ifm.TrapCause, 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
